// File: rtl/routex_tsched_pkg.sv
// Shared types for the RouteX traffic scheduler: event kinds, table entry layout, FSM states.
package routex_tsched_pkg;

    localparam int TSCHED_TIME_W = 32;
    localparam int TSCHED_LEN_W  = 64;
    localparam int TSCHED_PORTS  = 4;
    localparam int TSCHED_DEST   = 8;
    localparam int TSCHED_SLOT_W = $clog2(TSCHED_DEST);
    localparam int TSCHED_DEST_W = 64;

    typedef enum logic [1:0] {
        KIND_GO     = 2'd0,
        KIND_BP_SET = 2'd1,
        KIND_BP_CLR = 2'd2,
        KIND_END    = 2'd3
    } kind_e;

    typedef struct packed {
        logic [TSCHED_TIME_W-1:0] ev_time;
        kind_e                    kind;
        logic [TSCHED_PORTS-1:0]  mask;
        logic [TSCHED_SLOT_W-1:0] slot;
        logic [TSCHED_DEST_W-1:0] dest;
        logic [TSCHED_LEN_W-1:0]  len;
    } entry_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Entry value after reset: an END at time 0, so an unloaded table finishes at once.
    localparam entry_t END_ENTRY = '{
        ev_time: '0, kind: KIND_END, mask: '0, slot: '0, dest: '0, len: '0
    };

endpackage

// File: rtl/routex_tsched_table.sv
// Event table: flop array with one write port and a combinational read port.
// Latency: write visible the cycle after WE; read is same-cycle.
// Backpressure: none; writes are always accepted.
import routex_tsched_pkg::*;

module routex_tsched_table #(
    parameter  int NumEntries = 16,
    localparam int AW         = $clog2(NumEntries)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  entry_t        wentry,
    input  logic [AW-1:0] raddr,
    output entry_t        rentry
);

    entry_t mem [NumEntries];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NumEntries; i++) begin
                mem[i] <= END_ENTRY;
            end
        end else if (we) begin
            mem[waddr] <= wentry;
        end
    end

    assign rentry = mem[raddr];

endmodule

// File: rtl/routex_traffic_sched.sv
// Loadable stimulus sequencer driving per-port DEST/GO/LEN/BP of the traffic harness.
// Latency: an on-time event at time T is visible while CNT reads T+1; one entry per cycle.
// Backpressure: none; the run is free-running, only ABORT or completion stops it.
import routex_tsched_pkg::*;

module routex_traffic_sched #(
    parameter  int NumPorts   = 4,
    parameter  int NumDest    = 8,
    parameter  int NumEntries = 16,
    parameter  int TimeW      = 32,
    parameter  int LenW       = 64,
    localparam int AW         = $clog2(NumEntries),
    localparam int SW         = $clog2(NumDest)
) (
    input  logic                                   CLK,
    input  logic                                   RST,
    input  logic                                   WE,
    input  logic [AW-1:0]                          WADDR,
    input  logic [TimeW-1:0]                       WTIME,
    input  logic [1:0]                             WKIND,
    input  logic [NumPorts-1:0]                    WMASK,
    input  logic [SW-1:0]                          WSLOT,
    input  logic [63:0]                            WDEST,
    input  logic [LenW-1:0]                        WLEN,
    input  logic                                   START,
    input  logic                                   LOOP,
    input  logic                                   ABORT,
    output logic [NumPorts-1:0][NumDest-1:0][63:0] DEST,
    output logic [NumPorts-1:0]                    GO,
    output logic [NumPorts-1:0][LenW-1:0]          LEN,
    output logic [NumPorts-1:0]                    BP,
    output logic                                   BUSY,
    output logic                                   DONE,
    output logic                                   LATE,
    output logic                                   WERR,
    output logic [TimeW-1:0]                       CNT,
    output logic [AW-1:0]                          EVIDX
);

    state_e     state;
    logic       loop_q;
    entry_t     wentry;
    entry_t     cur_e;
    logic       fire;
    logic       late_hit;
    logic       last;
    logic [TimeW-1:0] cnt_inc;

    always_comb begin
        wentry         = END_ENTRY;
        wentry.ev_time = WTIME;
        wentry.kind    = kind_e'(WKIND);
        wentry.mask    = WMASK;
        wentry.slot    = WSLOT;
        wentry.dest    = WDEST;
        wentry.len     = WLEN;
    end

    // Table is frozen while running; a write attempt only raises WERR.
    routex_tsched_table #(
        .NumEntries (NumEntries)
    ) u_table (
        .CLK    (CLK),
        .RST    (RST),
        .we     (WE && (state == ST_IDLE)),
        .waddr  (WADDR),
        .wentry (wentry),
        .raddr  (EVIDX),
        .rentry (cur_e)
    );

    assign fire     = (cur_e.ev_time <= CNT);
    assign late_hit = (cur_e.ev_time < CNT);
    assign last     = (cur_e.kind == KIND_END) || (EVIDX == AW'(NumEntries - 1));
    assign cnt_inc  = (CNT == '1) ? CNT : CNT + TimeW'(1);
    assign BUSY     = (state == ST_RUN);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= ST_IDLE;
            loop_q <= 1'b0;
            DEST   <= '0;
            GO     <= '0;
            LEN    <= '0;
            BP     <= '0;
            DONE   <= 1'b0;
            LATE   <= 1'b0;
            WERR   <= 1'b0;
            CNT    <= '0;
            EVIDX  <= '0;
        end else begin
            GO <= '0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        state  <= ST_RUN;
                        loop_q <= LOOP;
                        CNT    <= '0;
                        EVIDX  <= '0;
                        DONE   <= 1'b0;
                        LATE   <= 1'b0;
                        WERR   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (WE) begin
                        WERR <= 1'b1;
                    end
                    // ABORT suppresses any event that would fire on the same edge.
                    if (ABORT) begin
                        state <= ST_IDLE;
                        BP    <= '0;
                    end else begin
                        CNT <= cnt_inc;
                        if (fire) begin
                            if (late_hit) begin
                                LATE <= 1'b1;
                            end
                            for (int p = 0; p < NumPorts; p++) begin
                                if (cur_e.mask[p]) begin
                                    unique case (cur_e.kind)
                                        KIND_GO: begin
                                            DEST[p][cur_e.slot] <= cur_e.dest;
                                            LEN[p]              <= cur_e.len;
                                            GO[p]               <= 1'b1;
                                        end
                                        KIND_BP_SET: BP[p] <= 1'b1;
                                        KIND_BP_CLR: BP[p] <= 1'b0;
                                        KIND_END:    ;
                                    endcase
                                end
                            end
                            if (last) begin
                                if (loop_q) begin
                                    CNT   <= '0;
                                    EVIDX <= '0;
                                end else begin
                                    state <= ST_IDLE;
                                    DONE  <= 1'b1;
                                end
                            end else begin
                                EVIDX <= EVIDX + AW'(1);
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
